// File: rtl/rtf_nimplus.sv
// GMII receiver for otsdaq UDP register commands addressed to this board; commits a
// single-cycle write or read request (plus frame_ok/frame_bad) one cycle after RXDV falls.
module rtf_nimplus (
   input  logic        PHY_RXCLK,
   input  logic        RESET,
   input  logic        PHY_RXCTL_RXDV,
   input  logic [7:0]  PHY_RXD,
   input  logic        PHY_RXER,
   output logic        wr_en,
   output logic [35:0] wr_addr,
   output logic [63:0] wr_data,
   output logic        rd_en,
   output logic [35:0] rd_addr,
   output logic [7:0]  rd_count,
   output logic        frame_ok,
   output logic        frame_bad
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_BODY, S_DROP, S_COMMIT} state_t;

   state_t      state_q;
   logic [10:0] cnt_q;
   logic [31:0] crc_q;
   logic        rxer_q;
   logic        is_wr_q;
   logic [7:0]  nwords_q;
   logic [35:0] addr_q;
   logic [63:0] data_q;

   logic        wr_en_q, rd_en_q, frame_ok_q, frame_bad_q;
   logic [35:0] wr_addr_q, rd_addr_q;
   logic [63:0] wr_data_q;
   logic [7:0]  rd_count_q;

   logic [31:0] crc_d;
   logic [8:0]  hdr_exp_d;
   logic        hdr_bad_d;
   logic        len_ok_d;
   logic        frame_good_d;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++)
         r[i] = v[31-i];
      return r;
   endfunction

   // {must_match, value} for each fixed header byte; offsets not listed are don't-care
   function automatic logic [8:0] hdr_byte(input logic [10:0] off);
      case (off)
         11'd0:   hdr_byte = 9'h100;
         11'd1:   hdr_byte = 9'h180;
         11'd2:   hdr_byte = 9'h155;
         11'd3:   hdr_byte = 9'h1ec;
         11'd4:   hdr_byte = 9'h100;
         11'd5:   hdr_byte = 9'h178;
         11'd12:  hdr_byte = 9'h108;
         11'd13:  hdr_byte = 9'h100;
         11'd14:  hdr_byte = 9'h145;
         11'd23:  hdr_byte = 9'h111;
         11'd30:  hdr_byte = 9'h1c0;
         11'd31:  hdr_byte = 9'h1a8;
         11'd32:  hdr_byte = 9'h12e;
         11'd33:  hdr_byte = 9'h178;
         11'd36:  hdr_byte = 9'h107;
         11'd37:  hdr_byte = 9'h1d7;
         default: hdr_byte = 9'h000;
      endcase
   endfunction

   always_comb begin
      crc_d        = crc_byte(crc_q, PHY_RXD);
      hdr_exp_d    = hdr_byte(cnt_q);
      hdr_bad_d    = hdr_exp_d[8] && (PHY_RXD != hdr_exp_d[7:0]);
      len_ok_d     = is_wr_q ? (cnt_q == 11'd64 && nwords_q == 8'd1)
                             : (cnt_q == 11'd56 && nwords_q != 8'd0);
      frame_good_d = len_ok_d && !rxer_q && (bitrev32(crc_q) == 32'hC704DD7B);
   end

   always_ff @(posedge PHY_RXCLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         crc_q       <= '1;
         rxer_q      <= 1'b0;
         is_wr_q     <= 1'b0;
         nwords_q    <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_bad_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_addr_q   <= '0;
         rd_count_q  <= '0;
      end else begin
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_bad_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (PHY_RXCTL_RXDV) begin
                  state_q <= S_PRE;
                  rxer_q  <= PHY_RXER;
               end
            end
            S_PRE: begin
               rxer_q <= rxer_q | PHY_RXER;
               if (!PHY_RXCTL_RXDV) begin
                  state_q <= S_IDLE;
               end else if (PHY_RXD == 8'hD5) begin
                  state_q <= S_BODY;
                  cnt_q   <= '0;
                  crc_q   <= '1;
                  is_wr_q <= 1'b0;
               end else if (PHY_RXD != 8'h55) begin
                  state_q <= S_DROP;
               end
            end
            S_BODY: begin
               if (!PHY_RXCTL_RXDV) begin
                  state_q <= S_COMMIT;
                  if (frame_good_d) begin
                     frame_ok_q <= 1'b1;
                     if (is_wr_q) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= data_q;
                     end else begin
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= addr_q;
                        rd_count_q <= nwords_q;
                     end
                  end else begin
                     frame_bad_q <= 1'b1;
                  end
               end else if (hdr_bad_d) begin
                  state_q <= S_DROP;
               end else begin
                  crc_q  <= crc_d;
                  rxer_q <= rxer_q | PHY_RXER;
                  if (cnt_q != 11'h7ff)
                     cnt_q <= cnt_q + 11'd1;
                  if (cnt_q == 11'd42)
                     is_wr_q <= PHY_RXD[0];
                  if (cnt_q == 11'd43)
                     nwords_q <= PHY_RXD;
                  // address bytes above bit 35 are discarded
                  for (int i = 0; i < 4; i++)
                     if (cnt_q == 11'(44 + i))
                        addr_q[i*8 +: 8] <= PHY_RXD;
                  if (cnt_q == 11'd48)
                     addr_q[35:32] <= PHY_RXD[3:0];
                  for (int i = 0; i < 8; i++)
                     if (cnt_q == 11'(52 + i))
                        data_q[i*8 +: 8] <= PHY_RXD;
               end
            end
            S_DROP: begin
               if (!PHY_RXCTL_RXDV)
                  state_q <= S_IDLE;
            end
            S_COMMIT: begin
               // a back-to-back frame may already be presenting preamble here
               state_q <= PHY_RXCTL_RXDV ? S_PRE : S_IDLE;
               rxer_q  <= PHY_RXCTL_RXDV & PHY_RXER;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign rd_count  = rd_count_q;
   assign frame_ok  = frame_ok_q;
   assign frame_bad = frame_bad_q;

endmodule

// File: tb/tb_rtf_nimplus.sv
// Scoreboard bench for rtf_nimplus: frames are built with their own CRC, expected
// commits are queued when RXDV falls and a negedge monitor checks every pulse.
module tb_rtf_nimplus;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rxdv = 1'b0;
   logic [7:0]  rxd = 8'h00;
   logic        rxer = 1'b0;
   logic        wr_en, rd_en, frame_ok, frame_bad;
   logic [35:0] wr_addr, rd_addr;
   logic [63:0] wr_data;
   logic [7:0]  rd_count;

   always #4 clk = ~clk;

   rtf_nimplus dut (
      .PHY_RXCLK      (clk),
      .RESET          (rst),
      .PHY_RXCTL_RXDV (rxdv),
      .PHY_RXD        (rxd),
      .PHY_RXER       (rxer),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .rd_en          (rd_en),
      .rd_addr        (rd_addr),
      .rd_count       (rd_count),
      .frame_ok       (frame_ok),
      .frame_bad      (frame_bad)
   );

   typedef struct {
      int          kind;   // 1 write ok, 2 read ok, 3 rejected
      logic [35:0] wa;
      logic [63:0] wd;
      logic [35:0] ra;
      logic [7:0]  rc;
      longint      cyc;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  frm[$];
   longint      cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [35:0] m_wa = '0, m_ra = '0;
   logic [63:0] m_wd = '0;
   logic [7:0]  m_rc = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic build_body(input bit wr, input logic [7:0] nw, input logic [63:0] addr,
                             input logic [63:0] data);
      logic [7:0] b[0:59];
      int         len;
      for (int i = 0; i < 60; i++) b[i] = 8'h00;
      b[0] = 8'h00; b[1] = 8'h80; b[2] = 8'h55; b[3] = 8'hec; b[4] = 8'h00; b[5] = 8'h78;
      b[6] = 8'h02; b[11] = 8'h01;
      b[12] = 8'h08; b[13] = 8'h00; b[14] = 8'h45; b[17] = 8'h2e; b[22] = 8'h40; b[23] = 8'h11;
      b[26] = 8'hc0; b[27] = 8'ha8; b[28] = 8'h2e; b[29] = 8'h01;
      b[30] = 8'hc0; b[31] = 8'ha8; b[32] = 8'h2e; b[33] = 8'h78;
      b[34] = 8'h07; b[35] = 8'hd7; b[36] = 8'h07; b[37] = 8'hd7; b[39] = 8'h1a;
      b[42] = wr ? 8'h01 : 8'h00;
      b[43] = nw;
      for (int i = 0; i < 8; i++) b[44+i] = addr[i*8 +: 8];
      for (int i = 0; i < 8; i++) b[52+i] = data[i*8 +: 8];
      len = wr ? 60 : 52;
      frm = {};
      for (int i = 0; i < len; i++) frm.push_back(b[i]);
   endtask

   task automatic add_fcs();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (frm[i]) begin
         c = c ^ {24'h0, frm[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) frm.push_back(c[i*8 +: 8]);
   endtask

   task automatic send_frame(input int kind, input int rxer_at, input int rst_at, input int gap);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rxdv = 1'b1;
         rxd  = (i == 7) ? 8'hD5 : 8'h55;
      end
      for (int i = 0; i < frm.size(); i++) begin
         @(negedge clk);
         rxd  = frm[i];
         rxer = (i == rxer_at);
         rst  = (i == rst_at);
         if (i == rst_at) begin
            m_wa = '0; m_wd = '0; m_ra = '0; m_rc = '0;
         end
      end
      @(negedge clk);
      rxdv = 1'b0; rxd = 8'h00; rxer = 1'b0; rst = 1'b0;
      if (kind != 0) begin
         e.kind = kind; e.wa = m_wa; e.wd = m_wd; e.ra = m_ra; e.rc = m_rc;
         e.cyc  = cyc + 1;
         sb.push_back(e);
      end
      repeat (gap - 1) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst && (wr_en || rd_en || frame_ok || frame_bad)) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {60'h0, wr_en, rd_en, frame_ok, frame_bad}, 64'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wr_en",     64'(wr_en),     64'(e.kind == 1));
            chk("rd_en",     64'(rd_en),     64'(e.kind == 2));
            chk("frame_ok",  64'(frame_ok),  64'(e.kind != 3));
            chk("frame_bad", 64'(frame_bad), 64'(e.kind == 3));
            chk("wr_addr",   64'(wr_addr),   64'(e.wa));
            chk("wr_data",   wr_data,        e.wd);
            chk("rd_addr",   64'(rd_addr),   64'(e.ra));
            chk("rd_count",  64'(rd_count),  64'(e.rc));
            chk("latency",   64'(cyc),       64'(e.cyc));
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wr_en",     64'(wr_en),     64'h0);
      chk("rst_rd_en",     64'(rd_en),     64'h0);
      chk("rst_frame_ok",  64'(frame_ok),  64'h0);
      chk("rst_frame_bad", 64'(frame_bad), 64'h0);
      chk("rst_wr_addr",   64'(wr_addr),   64'h0);
      chk("rst_wr_data",   wr_data,        64'h0);
      chk("rst_rd_addr",   64'(rd_addr),   64'h0);
      chk("rst_rd_count",  64'(rd_count),  64'h0);

      // valid write
      build_body(1'b1, 8'd1, 64'h3, 64'h0000000a12345678); add_fcs();
      m_wa = 36'h3; m_wd = 64'h0000000a12345678;
      send_frame(1, -1, -1, 5);

      // valid read
      build_body(1'b0, 8'd1, 64'h0, 64'h0); add_fcs();
      m_ra = 36'h0; m_rc = 8'd1;
      send_frame(2, -1, -1, 5);

      // corrupted FCS: rejected, held values unchanged
      build_body(1'b1, 8'd1, 64'h5, 64'hdead); add_fcs();
      frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
      send_frame(3, -1, -1, 5);

      // not addressed to us: wrong MAC, then wrong UDP port
      build_body(1'b1, 8'd1, 64'h5, 64'hdead);
      frm[5] = 8'h79; add_fcs();
      send_frame(0, -1, -1, 5);
      build_body(1'b1, 8'd1, 64'h5, 64'hdead);
      frm[37] = 8'hd8; add_fcs();
      send_frame(0, -1, -1, 5);

      // RXER inside an otherwise valid write
      build_body(1'b1, 8'd1, 64'h6, 64'hbeef); add_fcs();
      send_frame(3, 55, -1, 5);

      // write with numwords = 2, read with numwords = 0, write one byte too long
      build_body(1'b1, 8'd2, 64'h6, 64'hbeef); add_fcs();
      send_frame(3, -1, -1, 5);
      build_body(1'b0, 8'd0, 64'h6, 64'h0); add_fcs();
      send_frame(3, -1, -1, 5);
      build_body(1'b1, 8'd1, 64'h6, 64'hbeef); frm.push_back(8'h00); add_fcs();
      send_frame(3, -1, -1, 5);

      // read with address bits above 35 set and a multi-word count
      build_body(1'b0, 8'd4, 64'hFFFF_FFF9_8765_4321, 64'h0); add_fcs();
      m_ra = 36'h9_8765_4321; m_rc = 8'd4;
      send_frame(2, -1, -1, 5);

      // reset mid-frame, then a normal read
      build_body(1'b1, 8'd1, 64'h7, 64'h1234); add_fcs();
      send_frame(0, -1, 30, 3);
      build_body(1'b0, 8'd2, 64'h10, 64'h0); add_fcs();
      m_ra = 36'h10; m_rc = 8'd2;
      send_frame(2, -1, -1, 5);

      // back-to-back writes with a single idle cycle
      build_body(1'b1, 8'd1, 64'h11, 64'h1111_2222_3333_4444); add_fcs();
      m_wa = 36'h11; m_wd = 64'h1111_2222_3333_4444;
      send_frame(1, -1, -1, 1);
      build_body(1'b1, 8'd1, 64'h22, 64'h5555_6666_7777_8888); add_fcs();
      m_wa = 36'h22; m_wd = 64'h5555_6666_7777_8888;
      send_frame(1, -1, -1, 5);

      repeat (10) @(negedge clk);
      chk("pending_expected", 64'(sb.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
